button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 162 ++++++++++++++++
 tb/tb_button_conditioner.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel a two-flop synchronizer, a counter debouncer
// and a hold tracker that emits long-press and auto-repeat events.
module button_conditioner #(
   parameter int unsigned NUM_BUTTONS       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = 270_000,
   parameter int unsigned LONG_PRESS_CYCLES = 13_500_000,
   parameter int unsigned REPEAT_CYCLES     = 2_700_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] btn_n,
   output logic [NUM_BUTTONS-1:0] pressed,
   output logic [NUM_BUTTONS-1:0] press_pulse,
   output logic [NUM_BUTTONS-1:0] release_pulse,
   output logic [NUM_BUTTONS-1:0] long_press,
   output logic [NUM_BUTTONS-1:0] repeat_pulse
);

   localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                      LONG_PRESS_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

   // Counters compare against "one less" so the action lands on the edge where the
   // count would reach the parameter; the counter itself never holds that value.
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  =
      HOLD_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StRepeat
   } hold_state_e;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      logic              sync1_q;
      logic              sync_q;
      logic              stable_n_q, stable_n_d;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic              press_acc;
      logic              release_acc;
      hold_state_e       state_q, state_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic              long_done_q, long_done_d;
      logic              long_d, repeat_d;
      logic              press_pulse_q, release_pulse_q, long_q, repeat_q;

      // Two-flop synchronizer, reset to the released level.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1_q <= 1'b1;
            sync_q  <= 1'b1;
         end else begin
            sync1_q <= btn_n[i];
            sync_q  <= sync1_q;
         end
      end

      // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing edges.
      always_comb begin
         stable_n_d  = stable_n_q;
         db_cnt_d    = '0;
         press_acc   = 1'b0;
         release_acc = 1'b0;
         if (sync_q != stable_n_q) begin
            if (db_cnt_q == DB_LAST) begin
               stable_n_d  = sync_q;
               press_acc   = ~sync_q;
               release_acc = sync_q;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
      end

      // Hold tracker next state; an accepted release overrides any hold-count match.
      always_comb begin
         state_d     = state_q;
         hold_cnt_d  = hold_cnt_q;
         long_done_d = long_done_q;
         long_d      = 1'b0;
         repeat_d    = 1'b0;
         if (release_acc) begin
            state_d     = StIdle;
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (press_acc) begin
                     state_d     = StHold;
                     hold_cnt_d  = '0;
                     long_done_d = 1'b0;
                  end
               end
               StHold: begin
                  // With repeat disabled the channel parks here, counter frozen.
                  if (!long_done_q) begin
                     if (hold_cnt_q == LONG_LAST) begin
                        long_d     = 1'b1;
                        hold_cnt_d = '0;
                        if (REPEAT_CYCLES == 0) begin
                           long_done_d = 1'b1;
                        end else begin
                           state_d = StRepeat;
                        end
                     end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                     end
                  end
               end
               StRepeat: begin
                  if (hold_cnt_q == REP_LAST) begin
                     repeat_d   = 1'b1;
                     hold_cnt_d = '0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                  end
               end
               default: begin
                  state_d    = StIdle;
                  hold_cnt_d = '0;
               end
            endcase
         end
      end

      // State and registered event outputs.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stable_n_q      <= 1'b1;
            db_cnt_q        <= '0;
            state_q         <= StIdle;
            hold_cnt_q      <= '0;
            long_done_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_q          <= 1'b0;
            repeat_q        <= 1'b0;
         end else begin
            stable_n_q      <= stable_n_d;
            db_cnt_q        <= db_cnt_d;
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            long_done_q     <= long_done_d;
            press_pulse_q   <= press_acc;
            release_pulse_q <= release_acc;
            long_q          <= long_d;
            repeat_q        <= repeat_d;
         end
      end

      assign pressed[i]       = ~stable_n_q;
      assign press_pulse[i]   = press_pulse_q;
      assign release_pulse[i] = release_pulse_q;
      assign long_press[i]    = long_q;
      assign repeat_pulse[i]  = repeat_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: two instances (repeat enabled / disabled) share the button
// inputs and are compared every cycle against a history-based reference model.
module tb_button_conditioner;

   localparam int NB = 2;
   localparam int D  = 4;
   localparam int L  = 10;
   localparam int RA = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_n = '1;

   logic [NB-1:0] a_pr, a_pp, a_rp, a_lp, a_rep;
   logic [NB-1:0] b_pr, b_pp, b_rp, b_lp, b_rep;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(RA)
   ) dut_a (
      .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(a_pr), .press_pulse(a_pp),
      .release_pulse(a_rp), .long_press(a_lp), .repeat_pulse(a_rep)
   );

   button_conditioner #(
      .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(0)
   ) dut_b (
      .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(b_pr), .press_pulse(b_pp),
      .release_pulse(b_rp), .long_press(b_lp), .repeat_pulse(b_rep)
   );

   // Reference model: hist[c][k] is the raw level sampled k edges ago.
   bit            hist [NB][D+2];
   bit            st_n [NB];
   bit            held [2][NB];
   int            pedge [2][NB];
   int            cyc = 0;
   logic [NB-1:0] e_pr, e_pp, e_rp;
   logic [NB-1:0] e_lp [2];
   logic [NB-1:0] e_rep [2];

   function automatic void model_reset();
      for (int c = 0; c < NB; c++) begin
         for (int k = 0; k < D + 2; k++) hist[c][k] = 1'b1;
         st_n[c] = 1'b1;
         for (int d = 0; d < 2; d++) held[d][c] = 1'b0;
      end
      e_pr = '0; e_pp = '0; e_rp = '0;
      for (int d = 0; d < 2; d++) begin
         e_lp[d] = '0;
         e_rep[d] = '0;
      end
   endfunction

   function automatic void model_edge(input logic [NB-1:0] b);
      bit acc;
      int dt;
      int rp;
      cyc++;
      for (int c = 0; c < NB; c++) begin
         for (int k = D + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
         hist[c][0] = b[c];
         // The synchronized level seen at this edge is the sample from two edges ago;
         // accept when the last D such levels all differ from the stable level.
         acc = 1'b1;
         for (int k = 2; k <= D + 1; k++) if (hist[c][k] == st_n[c]) acc = 1'b0;
         e_pp[c] = acc && st_n[c];
         e_rp[c] = acc && !st_n[c];
         if (acc) st_n[c] = ~st_n[c];
         e_pr[c] = ~st_n[c];
         for (int d = 0; d < 2; d++) begin
            rp = (d == 0) ? RA : 0;
            e_lp[d][c] = 1'b0;
            e_rep[d][c] = 1'b0;
            if (e_pp[c]) begin
               held[d][c] = 1'b1;
               pedge[d][c] = cyc;
            end else if (e_rp[c]) begin
               held[d][c] = 1'b0;
            end else if (held[d][c]) begin
               dt = cyc - pedge[d][c];
               if (dt == L) e_lp[d][c] = 1'b1;
               else if (rp > 0 && dt > L && (dt - L) % rp == 0) e_rep[d][c] = 1'b1;
            end
         end
      end
   endfunction

   function automatic logic [10*NB-1:0] obs_vec();
      return {a_pr, a_pp, a_rp, a_lp, a_rep, b_pr, b_pp, b_rp, b_lp, b_rep};
   endfunction

   function automatic logic [10*NB-1:0] exp_vec();
      return {e_pr, e_pp, e_rp, e_lp[0], e_rep[0], e_pr, e_pp, e_rp, e_lp[1], e_rep[1]};
   endfunction

   task automatic tick(input logic [NB-1:0] b);
      btn_n = b;
      @(posedge clk);
      model_edge(b);
      #1;
   endtask

   task automatic settle();
      for (int j = 0; j < 25; j++) tick('1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_n = 2'b00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%05h exp=00000", obs_vec());
      end
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < D + 20; j++) begin
         tick(2'b00);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (j == D || j == D + 1) begin
            checks++;
            if (a_pr[0] !== (j == D + 1) || a_pp[0] !== (j == D + 1)) begin
               failures++;
               $display("FAIL press_latency edge=%0d got pr=%b pp=%b exp=%b", j, a_pr[0],
                        a_pp[0], (j == D + 1));
            end
         end
      end
      // Asynchronous reset mid-hold.
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs_vec() !== '0) begin
         failures++;
         $display("FAIL reset_async got=%05h exp=00000", obs_vec());
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < D + 3; j++) begin
         tick(2'b00);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rereset_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (j == D + 1) begin
            checks++;
            if (a_pp !== 2'b11) begin
               failures++;
               $display("FAIL fresh_press got=%b exp=11", a_pp);
            end
         end
      end
      settle();
   endtask

   task automatic test_bounce();
      logic [7:0] pat;
      int npp;
      int nrp;
      int at;
      pat = 8'b11001100;  // bit j = level at step j: 0,0,1,1,0,0,1,1
      npp = 0;
      nrp = 0;
      at = -1;
      for (int j = 0; j < 8 + D + 8; j++) begin
         tick({1'b1, (j < 8) ? pat[j] : 1'b0});
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL bounce_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (a_pp[0]) begin
            npp++;
            at = j;
         end
         if (a_rp[0]) nrp++;
      end
      checks++;
      if (npp != 1 || at != 8 + D + 1 || nrp != 0) begin
         failures++;
         $display("FAIL bounce_pulses got n=%0d at=%0d rel=%0d exp n=1 at=%0d rel=0", npp, at,
                  nrp, 8 + D + 1);
      end
      settle();
   endtask

   task automatic test_long_repeat();
      int nl;
      int nr;
      int nrel;
      int lat;
      nl = 0;
      nr = 0;
      lat = -1;
      for (int j = 0; j <= D + 26; j++) begin
         tick(2'b10);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL long_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (a_lp[0]) begin
            nl++;
            lat = j;
         end
         if (a_rep[0]) nr++;
      end
      checks++;
      if (nl != 1 || lat != D + 1 + L || nr != 5) begin
         failures++;
         $display("FAIL long_repeat_count got long=%0d at=%0d rep=%0d exp long=1 at=%0d rep=5",
                  nl, lat, nr, D + 1 + L);
      end
      nrel = 0;
      for (int j = 0; j < 20; j++) begin
         tick(2'b11);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL release_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (a_rp[0]) nrel++;
      end
      checks++;
      if (nrel != 1) begin
         failures++;
         $display("FAIL release_count got=%0d exp=1", nrel);
      end
      settle();
   endtask

   task automatic test_repeat_disabled();
      int bl;
      int br;
      int ar;
      bl = 0;
      br = 0;
      ar = 0;
      for (int j = 0; j < D + 52; j++) begin
         tick(2'b10);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL norep_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (b_lp[0]) bl++;
         if (b_rep[0]) br++;
         if (a_rep[0]) ar++;
      end
      checks++;
      if (bl != 1 || br != 0 || ar != (50 - L) / RA) begin
         failures++;
         $display("FAIL norep_count got long=%0d rep=%0d arep=%0d exp long=1 rep=0 arep=%0d",
                  bl, br, ar, (50 - L) / RA);
      end
      settle();
   endtask

   task automatic test_collision();
      for (int j = 0; j <= L + D + 3; j++) begin
         tick((j < L) ? 2'b10 : 2'b11);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL collide_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (j == L + D + 1) begin
            checks++;
            if (a_rp[0] !== 1'b1 || a_lp[0] !== 1'b0 || b_lp[0] !== 1'b0) begin
               failures++;
               $display("FAIL collide_release got rel=%b long=%b/%b exp rel=1 long=0/0",
                        a_rp[0], a_lp[0], b_lp[0]);
            end
         end
      end
      settle();
   endtask

   task automatic test_independence();
      int nr;
      int np1;
      nr = 0;
      np1 = 0;
      for (int j = 0; j < D + 17; j++) begin
         tick(2'b10);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL indep1_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (a_rep[0]) nr++;
      end
      for (int k = 0; k < D + 12; k++) begin
         tick(2'b00);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL indep2_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
         if (a_rep[0]) nr++;
         if (a_pp[1]) np1++;
         if (k == D + 1) begin
            checks++;
            if (a_pp[1] !== 1'b1) begin
               failures++;
               $display("FAIL indep_ch1_latency got=%b exp=1", a_pp[1]);
            end
         end
      end
      checks++;
      if (nr != (D + 27 - L) / RA || np1 != 1) begin
         failures++;
         $display("FAIL indep_counts got rep0=%0d pp1=%0d exp rep0=%0d pp1=1", nr, np1,
                  (D + 27 - L) / RA);
      end
      settle();
   endtask

   task automatic test_random();
      logic [NB-1:0] lv;
      int rem [NB];
      lv = '1;
      for (int c = 0; c < NB; c++) rem[c] = 1;
      for (int t = 0; t < 900; t++) begin
         for (int c = 0; c < NB; c++) begin
            rem[c]--;
            if (rem[c] <= 0) begin
               lv[c] = ~lv[c];
               rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) :
                                                     int'($urandom_range(4, 30));
            end
         end
         if (t == 450) begin
            rst = 1'b1;
            model_reset();
            #1;
            checks++;
            if (obs_vec() !== '0) begin
               failures++;
               $display("FAIL random_reset got=%05h exp=00000", obs_vec());
            end
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
         end
         tick(lv);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%05h exp=%05h", cyc, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_long_repeat();
      test_repeat_disabled();
      test_collision();
      test_independence();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
